// File: rtl/network_source.sv
// network_source: stream-to-network input adapter.
// Buffers up to two host words {run, spikes} and turns each word into one
// spike timestep followed by `run` all-zero timesteps on the network side.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// EMPTY    | count_q == 0, nothing to present, net_valid low
// SPIKE    | count_q  > 0, cnt_q == 0, head spike vector on net_inp
// IDLE_RUN | count_q  > 0, cnt_q  > 0, zero timesteps of the head's run
module network_source #(
   parameter int NET_NUM_INP = 4,
   parameter int RUN_WIDTH   = 8,
   localparam int SRC_WIDTH  = NET_NUM_INP + RUN_WIDTH
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   src_valid,
   output logic                   src_ready,
   input  logic [SRC_WIDTH-1:0]   src,
   output logic                   net_valid,
   input  logic                   net_ready,
   output logic [NET_NUM_INP-1:0] net_inp
);

   localparam logic [RUN_WIDTH-1:0] CNT_ONE = {{(RUN_WIDTH-1){1'b0}}, 1'b1};

   logic [SRC_WIDTH-1:0] head_q, head_d;
   logic [SRC_WIDTH-1:0] tail_q, tail_d;
   logic [1:0]           count_q, count_d;
   logic [RUN_WIDTH-1:0] cnt_q, cnt_d;

   logic                 push;
   logic                 beat;
   logic                 last_beat;
   logic                 pop;
   logic [RUN_WIDTH-1:0] head_run;

   assign head_run  = head_q[SRC_WIDTH-1:NET_NUM_INP];
   assign push      = src_valid && src_ready;
   assign beat      = net_valid && net_ready;
   assign last_beat = (cnt_q == head_run);
   assign pop       = beat && last_beat;

   // State register: FIFO slots, occupancy and beat index.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
         cnt_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: push into the first free slot, shift tail to head on pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      cnt_d   = cnt_q;

      if (beat) begin
         cnt_d = last_beat ? '0 : cnt_q + CNT_ONE;
      end

      unique case (count_q)
         2'd0: begin
            if (push) begin
               head_d  = src;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = src;
            end else if (push) begin
               tail_d  = src;
               count_d = 2'd2;
            end else if (pop) begin
               head_d  = '0;
               count_d = 2'd0;
            end
         end
         2'd2: begin
            // src_ready is low here, so only a pop can happen.
            if (pop) begin
               head_d  = tail_q;
               tail_d  = '0;
               count_d = 2'd1;
            end
         end
         default: begin
            count_d = 2'd0;
         end
      endcase
   end

   // Outputs: handshakes from registered count, spike vector bit-reversed on beat 0.
   always_comb begin
      src_ready = (count_q != 2'd2);
      net_valid = (count_q != 2'd0);
      net_inp   = '0;
      if (net_valid && (cnt_q == '0)) begin
         for (int i = 0; i < NET_NUM_INP; i++) begin
            net_inp[i] = head_q[NET_NUM_INP-1-i];
         end
      end
   end

endmodule

// File: tb/tb_network_source.sv
// Directed self-checking bench for network_source (NET_NUM_INP=4, RUN_WIDTH=4).
module tb_network_source;

   logic       clk;
   logic       arstn;
   logic       src_valid;
   logic       src_ready;
   logic [7:0] src;
   logic       net_valid;
   logic       net_ready;
   logic [3:0] net_inp;

   int n_checks = 0;
   int n_fails  = 0;

   network_source #(.NET_NUM_INP(4), .RUN_WIDTH(4)) dut (
      .clk       (clk),
      .arstn     (arstn),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src       (src),
      .net_valid (net_valid),
      .net_ready (net_ready),
      .net_inp   (net_inp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_idle [4]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0000};
   logic [7:0] words    [3]  = '{8'h11, 8'h08, 8'hF1};
   logic [3:0] exp_strm [19];

   initial begin
      int  widx;
      logic acc;

      arstn     = 1'b0;
      src_valid = 1'b0;
      src       = 8'h00;
      net_ready = 1'b0;
      #12;
      chk("rst_valid", {31'd0, net_valid}, 32'd0);
      chk("rst_inp",   {28'd0, net_inp},   32'd0);
      chk("rst_ready", {31'd0, src_ready}, 32'd1);
      arstn = 1'b1;
      tick();
      tick();
      chk("post_rst_idle", {31'd0, net_valid}, 32'd0);

      // Single word, R=0.
      net_ready = 1'b1;
      src = 8'h01; src_valid = 1'b1;
      tick();
      src_valid = 1'b0;
      chk("single_valid", {31'd0, net_valid}, 32'd1);
      chk("single_inp",   {28'd0, net_inp},   32'h8);
      tick();
      chk("single_done", {31'd0, net_valid}, 32'd0);

      // Idle run, R=3.
      src = 8'h3A; src_valid = 1'b1;
      tick();
      src_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("idle_valid%0d", b), {31'd0, net_valid}, 32'd1);
         chk($sformatf("idle_inp%0d", b),   {28'd0, net_inp},   {28'd0, exp_idle[b]});
         tick();
      end
      chk("idle_done", {31'd0, net_valid}, 32'd0);
      chk("idle_cnt",  {28'd0, dut.cnt_q}, 32'd0);

      // Backpressure, R=2.
      net_ready = 1'b0;
      src = 8'h2F; src_valid = 1'b1;
      tick();
      src_valid = 1'b0;
      for (int b = 0; b < 5; b++) begin
         chk($sformatf("stall_valid%0d", b), {31'd0, net_valid}, 32'd1);
         chk($sformatf("stall_inp%0d", b),   {28'd0, net_inp},   32'hF);
         tick();
      end
      net_ready = 1'b1;
      chk("bp_beat0", {28'd0, net_inp}, 32'hF);
      tick();
      chk("bp_beat1_v", {31'd0, net_valid}, 32'd1);
      chk("bp_beat1",   {28'd0, net_inp},   32'h0);
      tick();
      chk("bp_beat2_v", {31'd0, net_valid}, 32'd1);
      chk("bp_beat2",   {28'd0, net_inp},   32'h0);
      tick();
      chk("bp_done", {31'd0, net_valid}, 32'd0);

      // Full FIFO with a held request.
      net_ready = 1'b0;
      src = 8'h01; src_valid = 1'b1;
      tick();
      src = 8'h02;
      tick();
      src = 8'h04;
      chk("full_ready0", {31'd0, src_ready}, 32'd0);
      tick();
      chk("full_ready1", {31'd0, src_ready}, 32'd0);
      chk("full_hold",   {28'd0, net_inp},   32'h8);
      net_ready = 1'b1;
      tick();
      chk("full_b1_v",   {31'd0, net_valid}, 32'd1);
      chk("full_b1",     {28'd0, net_inp},   32'h4);
      chk("full_ready2", {31'd0, src_ready}, 32'd1);
      tick();
      src_valid = 1'b0;
      chk("full_b2_v", {31'd0, net_valid}, 32'd1);
      chk("full_b2",   {28'd0, net_inp},   32'h2);
      tick();
      chk("full_done", {31'd0, net_valid}, 32'd0);

      // Streaming without bubbles.
      for (int b = 0; b < 19; b++) exp_strm[b] = 4'h0;
      exp_strm[0] = 4'b1000;
      exp_strm[2] = 4'b0001;
      exp_strm[3] = 4'b1000;
      net_ready = 1'b1;
      widx = 0;
      src = words[0]; src_valid = 1'b1;
      tick();
      widx = 1;
      src = words[1];
      for (int b = 0; b < 19; b++) begin
         chk($sformatf("strm_valid%0d", b), {31'd0, net_valid}, 32'd1);
         chk($sformatf("strm_inp%0d", b),   {28'd0, net_inp},   {28'd0, exp_strm[b]});
         acc = src_valid && src_ready;
         tick();
         if (acc) begin
            widx++;
            if (widx < 3) src = words[widx];
            else src_valid = 1'b0;
         end
      end
      chk("strm_done", {31'd0, net_valid}, 32'd0);

      // Asynchronous reset with two words buffered.
      net_ready = 1'b0;
      src = 8'h31; src_valid = 1'b1;
      tick();
      src = 8'h0C;
      tick();
      src_valid = 1'b0;
      chk("pre_rst_full", {31'd0, src_ready}, 32'd0);
      #2;
      arstn = 1'b0;
      #1;
      chk("arst_valid", {31'd0, net_valid}, 32'd0);
      chk("arst_inp",   {28'd0, net_inp},   32'd0);
      chk("arst_ready", {31'd0, src_ready}, 32'd1);
      tick();
      arstn = 1'b1;
      net_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tick();
         chk($sformatf("arst_quiet%0d", b), {31'd0, net_valid}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
